// File: rtl/dmem_sched_pkg.sv
// Shared types and constants for the MEM-stage dual-lane data memory scheduler.
package dmem_sched_pkg;
  localparam int REQ_AW   = 32;
  localparam int REQ_DW   = 32;
  localparam int WORD_LSB = 2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DEFER = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_DEFER = ST_DEFER
  } state_e;

  typedef struct packed {
    logic              re;
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wd;
  } mem_req_t;

  // Store wins over load; address/data are zeroed when they carry no meaning
  // so an idle memory port never sees stray values.
  function automatic mem_req_t mk_req(input logic re, input logic we,
                                      input logic [REQ_AW-1:0] addr,
                                      input logic [REQ_DW-1:0] wd);
    mem_req_t r;
    r.we   = we;
    r.re   = re & ~we;
    r.addr = (re | we) ? addr : '0;
    r.wd   = we ? wd : '0;
    return r;
  endfunction
endpackage

// File: rtl/dmem_conflict_detect.sv
// Combinational same-word hazard check between the two MEM-stage lanes.
module dmem_conflict_detect #(
  parameter int WW = 30
) (
  input  logic          l1_re,
  input  logic          l1_we,
  input  logic [WW-1:0] l1_word,
  input  logic          l2_re,
  input  logic          l2_we,
  input  logic [WW-1:0] l2_word,
  output logic          conflict,
  output logic          ww_conflict
);
  logic act1, act2;

  always_comb begin
    act1        = l1_re | l1_we;
    act2        = l2_re | l2_we;
    conflict    = act1 & act2 & (l1_we | l2_we) & (l1_word == l2_word);
    ww_conflict = conflict & l1_we & l2_we;
  end
endmodule

// File: rtl/dmem_port_scheduler.sv
// Routes two MEM lanes onto the dual-ported data memory, serialising same-word hazards.
// Optional stats counters are enabled with DMEM_SCHED_STATS_EN.
module dmem_port_scheduler
  import dmem_sched_pkg::*;
#(
  parameter int AW       = REQ_AW,
  parameter int DW       = REQ_DW,
  parameter int WORD_LSB = dmem_sched_pkg::WORD_LSB
) (
  input  logic          Clk,
  input  logic          Rst,
`ifdef DMEM_SCHED_STATS_EN
  output logic [31:0]   conflict_cnt,
  output logic [31:0]   ww_cnt,
`endif
  input  logic          l1_re,
  input  logic          l1_we,
  input  logic [AW-1:0] l1_addr,
  input  logic [DW-1:0] l1_wd,
  input  logic          l2_re,
  input  logic          l2_we,
  input  logic [AW-1:0] l2_addr,
  input  logic [DW-1:0] l2_wd,
  output logic [DW-1:0] l1_rd,
  output logic [DW-1:0] l2_rd,
  output logic          l1_done,
  output logic          l2_done,
  output logic          stall,
  output logic          RE1,
  output logic          WE1,
  output logic [AW-1:0] A1,
  output logic [DW-1:0] WD1,
  output logic          RE2,
  output logic          WE2,
  output logic [AW-1:0] A2,
  output logic [DW-1:0] WD2,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2
);
  state_e        state_q, state_d;
  mem_req_t      hold_q, hold_d;
  logic [DW-1:0] rd1_hold_q, rd1_hold_d;
  mem_req_t      req1, req2, p1, p2;
  logic          conflict, ww_conflict;

  dmem_conflict_detect #(.WW(AW-WORD_LSB)) u_detect (
    .l1_re      (l1_re),
    .l1_we      (l1_we),
    .l1_word    (l1_addr[AW-1:WORD_LSB]),
    .l2_re      (l2_re),
    .l2_we      (l2_we),
    .l2_word    (l2_addr[AW-1:WORD_LSB]),
    .conflict   (conflict),
    .ww_conflict(ww_conflict)
  );

  always_comb begin
    req1       = mk_req(l1_re, l1_we, l1_addr, l1_wd);
    req2       = mk_req(l2_re, l2_we, l2_addr, l2_wd);
    state_d    = state_q;
    hold_d     = hold_q;
    rd1_hold_d = rd1_hold_q;
    p1         = '0;
    p2         = '0;
    l1_rd      = RD1;
    l2_rd      = RD2;
    l1_done    = 1'b0;
    l2_done    = 1'b0;
    stall      = 1'b0;
    // While reset is high every enable/flag stays low, even with active lanes.
    if (!Rst) begin
      unique case (state_q)
        S_IDLE: begin
          p1 = req1;
          if (conflict) begin
            hold_d  = req2;
            if (req1.re) rd1_hold_d = RD1;
            stall   = 1'b1;
            state_d = S_DEFER;
          end else begin
            p2      = req2;
            l1_done = req1.re | req1.we;
            l2_done = req2.re | req2.we;
          end
        end
        S_DEFER: begin
          p2      = hold_q;
          l1_rd   = rd1_hold_q;
          // A conflict needs lane 1 active, so its deferred done is always set.
          l1_done = 1'b1;
          l2_done = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    RE1 = p1.re;
    WE1 = p1.we;
    A1  = p1.addr;
    WD1 = p1.wd;
    RE2 = p2.re;
    WE2 = p2.we;
    A2  = p2.addr;
    WD2 = p2.wd;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      rd1_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rd1_hold_q <= rd1_hold_d;
    end
  end

`ifdef DMEM_SCHED_STATS_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] ww_cnt_q, ww_cnt_d;
  logic        take;

  always_comb begin
    take           = (state_q == S_IDLE) & conflict;
    conflict_cnt_d = conflict_cnt_q;
    ww_cnt_d       = ww_cnt_q;
    if (take && !(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + 32'd1;
    if (take && ww_conflict && !(&ww_cnt_q)) ww_cnt_d = ww_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      conflict_cnt_q <= '0;
      ww_cnt_q       <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      ww_cnt_q       <= ww_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign ww_cnt       = ww_cnt_q;
`else
  logic unused_ww;
  assign unused_ww = ww_conflict;
`endif
endmodule
